// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory read port and decode handshake.
// The fetch unit connects through the master modport; memory/decode side uses slave.
interface fetch_unit_if #(
  parameter int XLEN       = 64,
  parameter int IMEM_DEPTH = 1024
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_inv_addr;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_inv_addr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_inv_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: PC/FSM, one-deep in-flight memory read, FIFO to decode.
// Optional FETCH_STATS_EN adds perf_fetched / perf_flushed counters.
module fetch_unit #(
  parameter int              XLEN       = 64,
  parameter int              IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_flushed
`endif
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, FAULT_PEND, HALT} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            inv;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] infl_pc;
  logic            inflight;
  entry_t          fifo [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;

  logic   redir, pc_bad, credit, issue, resp_push, fault_push, push, pop;
  entry_t push_entry;

  assign redir  = bus.redirect_valid;
  assign pc_bad = (pc[1:0] != 2'b00) || ((pc >> 2) >= XLEN'(IMEM_DEPTH));
  // Credit uses the registered count only; a same-cycle pop frees its slot next cycle.
  assign credit = (int'(count) + int'(inflight)) < FIFO_DEPTH;

  // rst gates the strobe so nothing is requested while reset is held.
  assign issue      = ~rst & ~redir & (state == RUN) & ~pc_bad & credit;
  assign resp_push  = inflight & ~redir;
  assign fault_push = ~redir & (state == FAULT_PEND) & ~inflight & (int'(count) < FIFO_DEPTH);
  assign push       = resp_push | fault_push;
  assign pop        = bus.if_valid & bus.if_ready & ~redir;

  always_comb begin
    push_entry = '0;
    if (resp_push) begin
      push_entry.instr = bus.imem_rdata;
      push_entry.pc    = infl_pc;
      push_entry.inv   = 1'b0;
    end else begin
      push_entry.instr = '0;
      push_entry.pc    = pc;
      push_entry.inv   = 1'b1;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc[AW+1:2];
  assign bus.if_valid    = (count != '0);
  assign bus.if_instr    = fifo[rd_ptr].instr;
  assign bus.if_pc       = fifo[rd_ptr].pc;
  assign bus.if_inv_addr = fifo[rd_ptr].inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      infl_pc  <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else if (redir) begin
      // Keep rd_ptr so the (now invalid) head outputs stay stable after the flush.
      state    <= RUN;
      pc       <= bus.redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= rd_ptr;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_pc <= pc;
        pc      <= pc + XLEN'(4);
      end
      case (state)
        RUN:        if (pc_bad) state <= FAULT_PEND;
        FAULT_PEND: if (fault_push) state <= HALT;
        default:    state <= state;
      endcase
      if (push) begin
        fifo[wr_ptr] <= push_entry;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      // Flush loses every buffered entry plus the response arriving this cycle.
      if (redir) perf_flushed <= perf_flushed + 32'(count) + 32'(inflight);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected entries are queued when stimulus is applied
// and compared by a monitor as decode handshakes occur.
module tb_fetch_unit;
  localparam int XLEN       = 64;
  localparam int IMEM_DEPTH = 1024;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  fetch_unit_if #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  fetch_unit #(
    .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(64'h0), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STATS_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: word i holds 0x1000+i.
  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= 32'h1000 + 32'(bus.imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.if_valid && bus.if_ready) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_pc", bus.if_pc, e.pc);
        chk("out_instr", 64'(bus.if_instr), 64'(e.instr));
        chk("out_inv", 64'(bus.if_inv_addr), 64'(e.inv));
      end else begin
        chk("extra_out_valid", 64'(bus.if_valid), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_seq(input logic [XLEN-1:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + XLEN'(4 * i);
      e.instr = 32'h1000 + 32'(e.pc[11:2]);
      e.inv   = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic push_fault(input logic [XLEN-1:0] p);
    exp_t e;
    e.pc = p; e.instr = '0; e.inv = 1'b1;
    sb.push_back(e);
  endtask

  // Wait for all expected outputs, then stop accepting right after the last handshake.
  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    bus.if_ready = 1'b0;
    chk("drain_left", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic redirect_to(input logic [XLEN-1:0] target, input logic rdy);
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
    bus.if_ready       = rdy;
  endtask

  initial begin
    int n;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_if_instr", 64'(bus.if_instr), 64'd0);
    chk("rst_if_pc", bus.if_pc, 64'd0);
    chk("rst_if_inv", 64'(bus.if_inv_addr), 64'd0);
`ifdef FETCH_STATS_EN
    chk("rst_perf_fetched", 64'(perf_fetched), 64'd0);
`endif

    // Release reset: request at once, if_valid two cycles later, then one per cycle
    push_seq(64'h0, 12);
    bus.if_ready = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", 64'(bus.imem_req), 64'd1);
    chk("first_addr", 64'(bus.imem_addr), 64'd0);
    n = 1;
    while (!bus.if_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid_lat", 64'(n), 64'd3);
    repeat (11) begin
      @(negedge clk);
      chk("stream_nogap", 64'(bus.if_valid), 64'd1);
    end
    drain(20);
`ifdef FETCH_STATS_EN
    chk("perf_fetched_12", 64'(perf_fetched), 64'd12);
`endif

    // Backpressure: buffer fills, requests stop, stream resumes in order
    repeat (10) tick();
    @(negedge clk);
    chk("stall_valid", 64'(bus.if_valid), 64'd1);
    chk("stall_no_req", 64'(bus.imem_req), 64'd0);
    tick();
    push_seq(64'h30, 8);
    bus.if_ready = 1'b1;
    drain(40);

    // One stalled cycle leaves 3 buffered + 1 in flight; redirect discards all
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h40;
    push_seq(64'h40, 4);
    @(negedge clk);
    chk("redir_no_req", 64'(bus.imem_req), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b1;
    @(negedge clk);
    chk("redir_t1_req", 64'(bus.imem_req), 64'd1);
    chk("redir_t1_addr", 64'(bus.imem_addr), 64'h10);
    chk("redir_t1_valid", 64'(bus.if_valid), 64'd0);
`ifdef FETCH_STATS_EN
    chk("perf_flushed_4", 64'(perf_flushed), 64'd4);
`endif
    @(negedge clk);
    chk("redir_t2_valid", 64'(bus.if_valid), 64'd0);
    @(negedge clk);
    chk("redir_t3_valid", 64'(bus.if_valid), 64'd1);
    drain(20);

    // Misaligned target: single fault entry, no requests, stays halted
    push_fault(64'h42);
    redirect_to(64'h42, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("halt_no_req", 64'(bus.imem_req), 64'd0);
    end
    chk("halt_fault_seen", 64'(sb.size()), 64'd0);
    chk("halt_empty", 64'(bus.if_valid), 64'd0);
    drain(2);

    // Resume from HALT near the end of memory: last words then out-of-range fault
    push_seq(64'hFF0, 4);
    push_fault(64'h1000);
    redirect_to(64'hFF0, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (4) begin
      @(negedge clk);
      chk("end_no_req", 64'(bus.imem_req), 64'd0);
    end
    chk("end_empty", 64'(bus.if_valid), 64'd0);
    drain(2);

    // Top of the address space is out of range
    push_fault(64'hFFFF_FFFF_FFFF_FFFC);
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    drain(20);

    // One-cycle reset with a full buffer
    redirect_to(64'h0, 1'b0);
    repeat (8) tick();
    chk("full_valid", 64'(bus.if_valid), 64'd1);
    chk("full_no_req", 64'(bus.imem_req), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.if_valid), 64'd0);
    chk("midrst_req", 64'(bus.imem_req), 64'd0);
    tick();
    rst = 1'b0;
    push_seq(64'h0, 8);
    bus.if_ready = 1'b1;
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
